serial_mayor: RTL and testbench



---
 rtl/serial_mayor_pkg.sv | 16 +
 rtl/serial_mayor_bit.sv | 32 +++
 rtl/serial_mayor.sv | 109 ++++++++++
 tb/tb_serial_mayor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mayor_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state and per-bit decision codes.
package serial_mayor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      A_GT = 2'd0,
      B_GT = 2'd1,
      EQ   = 2'd2
   } dec_t;

endpackage

// File: rtl/serial_mayor_bit.sv
// One-bit decision cell. With SERIAL_MAYOR_SIGNED_EN defined, the sign-bit decision is
// inverted so two's complement operands order correctly.
module serial_mayor_bit
   import serial_mayor_pkg::*;
(
   input  logic i_a,
   input  logic i_b,
   input  logic i_is_msb,
   output dec_t o_dec
);

   always_comb begin
      o_dec = EQ;
      if (i_a && !i_b) begin
         o_dec = A_GT;
      end else if (!i_a && i_b) begin
         o_dec = B_GT;
      end
`ifdef SERIAL_MAYOR_SIGNED_EN
      // A set sign bit marks the smaller operand.
      if (i_is_msb && (i_a != i_b)) begin
         o_dec = i_a ? B_GT : A_GT;
      end
`endif
   end

`ifndef SERIAL_MAYOR_SIGNED_EN
   logic w_unused_msb;
   assign w_unused_msb = i_is_msb;
`endif

endmodule

// File: rtl/serial_mayor.sv
// Bit-serial MSB-first comparator / max selector with start/done handshake and early exit.
// Optional signed mode: define SERIAL_MAYOR_SIGNED_EN.
module serial_mayor
   import serial_mayor_pkg::*;
#(
   parameter int WIDTH = 4
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic             sm_selector,
   output logic             sm_distintos,
   output logic [WIDTH-1:0] sm_mayor,
   output logic [1:0]       o_dbg_state
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_selector;
   logic             r_distintos;
   logic [WIDTH-1:0] r_mayor;

   logic w_bit_a;
   logic w_bit_b;
   logic w_is_msb;
   dec_t w_dec;

   assign w_bit_a  = r_a[r_idx];
   assign w_bit_b  = r_b[r_idx];
   assign w_is_msb = (r_idx == IDX_MSB);

   serial_mayor_bit u_bit (
      .i_a      (w_bit_a),
      .i_b      (w_bit_b),
      .i_is_msb (w_is_msb),
      .o_dec    (w_dec)
   );

   // start is honoured from DONE as well as IDLE, allowing a 2-cycle initiation interval.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_idx       <= IDX_MSB;
         r_selector  <= 1'b0;
         r_distintos <= 1'b0;
         r_mayor     <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a     <= op_a;
                  r_b     <= op_b;
                  r_idx   <= IDX_MSB;
                  r_state <= COMPARE;
               end else begin
                  r_state <= IDLE;
               end
            end
            COMPARE: begin
               case (w_dec)
                  B_GT: begin
                     r_selector  <= 1'b1;
                     r_distintos <= 1'b1;
                     r_mayor     <= r_b;
                     r_state     <= DONE;
                  end
                  A_GT: begin
                     r_selector  <= 1'b0;
                     r_distintos <= 1'b1;
                     r_mayor     <= r_a;
                     r_state     <= DONE;
                  end
                  default: begin
                     if (r_idx == '0) begin
                        r_selector  <= 1'b0;
                        r_distintos <= 1'b0;
                        r_mayor     <= r_a;
                        r_state     <= DONE;
                     end else begin
                        r_idx <= r_idx - 1'b1;
                     end
                  end
               endcase
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy         = (r_state == COMPARE);
   assign done         = (r_state == DONE);
   assign sm_selector  = r_selector;
   assign sm_distintos = r_distintos;
   assign sm_mayor     = r_mayor;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_serial_mayor.sv
// Directed bench for serial_mayor (WIDTH=4): latency, results, back-to-back, reset abort, signedness.
module tb_serial_mayor;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       busy;
   logic       done;
   logic       sm_selector;
   logic       sm_distintos;
   logic [3:0] sm_mayor;
   logic [1:0] o_dbg_state;

   int checks = 0;
   int errors = 0;
   int lat;

   serial_mayor #(.WIDTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .op_a         (op_a),
      .op_b         (op_b),
      .busy         (busy),
      .done         (done),
      .sm_selector  (sm_selector),
      .sm_distintos (sm_distintos),
      .sm_mayor     (sm_mayor),
      .o_dbg_state  (o_dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a comparison, scrambles the operand inputs afterwards, and returns edges until done.
   task automatic run_cmp(input logic [3:0] a, input logic [3:0] b, output int n_edges);
      op_a = a;
      op_b = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      op_a = ~a;
      op_b = ~b;
      n_edges = -1;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (done) begin
            n_edges = n;
            break;
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op_a  = 4'b0000;
      op_b  = 4'b0000;
      tick();
      tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sel", sm_selector, 0);
      check("rst_dis", sm_distintos, 0);
      check("rst_mayor", sm_mayor, 0);
      check("rst_state", o_dbg_state, 0);

      // reset and start together: reset wins
      start = 1'b1;
      op_a  = 4'b1111;
      tick();
      check("rst_start_busy", busy, 0);
      start = 1'b0;
      reset = 1'b0;
      tick();

      // MSB differs
      run_cmp(4'b1010, 4'b0111, lat);
      check("t1_lat", lat, 1);
      check("t1_dis", sm_distintos, 1);
`ifdef SERIAL_MAYOR_SIGNED_EN
      check("t1_sel", sm_selector, 1);
      check("t1_mayor", sm_mayor, 4'b0111);
`else
      check("t1_sel", sm_selector, 0);
      check("t1_mayor", sm_mayor, 4'b1010);
`endif
      check("t1_busy", busy, 0);
      tick();
      check("t1_done_pulse", done, 0);
      check("t1_hold", sm_distintos, 1);
      check("t1_idle", o_dbg_state, 0);

      // LSB differs, B larger
      run_cmp(4'b0010, 4'b0011, lat);
      check("t2_lat", lat, 4);
      check("t2_sel", sm_selector, 1);
      check("t2_dis", sm_distintos, 1);
      check("t2_mayor", sm_mayor, 4'b0011);
      tick();

      // tie
      run_cmp(4'b0101, 4'b0101, lat);
      check("t3_lat", lat, 4);
      check("t3_sel", sm_selector, 0);
      check("t3_dis", sm_distintos, 0);
      check("t3_mayor", sm_mayor, 4'b0101);
      tick();

      // back-to-back: start held through COMPARE and DONE
      op_a  = 4'b1000;
      op_b  = 4'b0000;
      start = 1'b1;
      tick();
      op_a = 4'b0000;
      op_b = 4'b0100;
      check("b2b_busy0", busy, 1);
      tick();
      check("b2b_done1", done, 1);
`ifdef SERIAL_MAYOR_SIGNED_EN
      check("b2b_sel1", sm_selector, 1);
      check("b2b_mayor1", sm_mayor, 4'b0000);
`else
      check("b2b_sel1", sm_selector, 0);
      check("b2b_mayor1", sm_mayor, 4'b1000);
`endif
      tick();
      start = 1'b0;
      check("b2b_busy2", busy, 1);
      check("b2b_nodone2", done, 0);
      tick();
      check("b2b_nodone3", done, 0);
      tick();
      check("b2b_done2", done, 1);
      check("b2b_sel2", sm_selector, 1);
      check("b2b_dis2", sm_distintos, 1);
      check("b2b_mayor2", sm_mayor, 4'b0100);
      tick();

      // reset one cycle into COMPARE
      op_a  = 4'b0001;
      op_b  = 4'b0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort_busy_pre", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sel", sm_selector, 0);
      check("abort_dis", sm_distintos, 0);
      check("abort_mayor", sm_mayor, 0);
      for (int k = 0; k < 5; k++) begin
         tick();
         check("abort_no_done", done, 0);
      end

      // signedness
      run_cmp(4'b1000, 4'b0001, lat);
      check("sgn_lat", lat, 1);
      check("sgn_dis", sm_distintos, 1);
`ifdef SERIAL_MAYOR_SIGNED_EN
      check("sgn_sel", sm_selector, 1);
      check("sgn_mayor", sm_mayor, 4'b0001);
`else
      check("sgn_sel", sm_selector, 0);
      check("sgn_mayor", sm_mayor, 4'b1000);
`endif
      tick();
      check("sgn_idle", o_dbg_state, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
